ram_burst_ctrl: RTL and testbench

- Burst command front-end that sits directly upstream of the single-port RAM.
- Accepts one burst command at a time (write or read, BURST_LEN words) from a host over valid/ready handshakes.
- Sequences per-word RAM accesses at incrementing, wrapping addresses.
- Returns read data through a back-pressurable stream with a last-beat marker.

---
 rtl/ram_burst_ctrl_pkg.sv | 30 +++
 rtl/ram_burst_rfifo.sv | 75 +++++++
 rtl/ram_burst_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_ctrl_pkg.sv
// ram_burst_ctrl_pkg
// Shared definitions for the RAM burst front-end and its RAM-side helpers:
// default data/address widths, the default burst length, the controller
// state encoding and a small helper for sizing the word counters.
// No ports (package).

package ram_burst_ctrl_pkg;

  // Default geometry of the RAM behind the controller.
  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 8;
  localparam int DEPTH_DEF     = 2 ** ADDR_W_DEF;

  // Default words per burst (power of two, 2..256).
  localparam int BURST_LEN_DEF = 8;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  // Word counters must be able to hold the value BURST_LEN itself (the read
  // issue counter stops there), so they get one bit more than log2.
  function automatic int cnt_width(input int len);
    return $clog2(len) + 1;
  endfunction

endpackage

// File: rtl/ram_burst_rfifo.sv
// ram_burst_rfifo
// Two-entry synchronous FIFO used to hold RAM read data until the consumer
// takes it. Push and pop may happen in the same cycle; a pop on an empty
// FIFO is ignored. A push into a full FIFO without a simultaneous pop is a
// design error in the surrounding logic and is flagged by an assertion.
//
// Ports:
//   clk        in   clock
//   rstn       in   synchronous active-low reset; clears storage and count
//   push       in   write push_data at the tail
//   push_data  in   W-bit data to store
//   pop        in   drop the head entry
//   count      out  occupancy, 0..2
//   head       out  oldest entry (0 after reset)
//   empty      out  count == 0

module ram_burst_rfifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head,
  output logic         empty
);

  logic [W-1:0] store [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         full;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot wr_ptr points at, so the push may proceed.
  assign do_push = push && (!full || do_pop);
  assign head    = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      store[0] <= '0;
      store[1] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Overflow can only come from a broken issue-credit scheme upstream.
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(push && full && !do_pop));
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
// Burst command front-end for a single-port RAM. Accepts one write or read
// burst of BURST_LEN words at a time, sequences the per-word RAM accesses at
// base+index (wrapping modulo 2**ADDR_W) and streams read data back through
// a two-entry FIFO with a last-beat marker.
//
// Handshakes: every channel (cmd, wdata, rdata) transfers on a rising clock
// edge where its valid and ready are both 1. Valid may be raised without
// waiting for ready; ready may depend on state only (cmd, wdata) or on FIFO
// occupancy (rdata_valid). cmd_valid is ignored outside IDLE and wdata_valid
// outside WRITE.
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   cmd_valid/ready  command handshake; cmd_wr selects write (1) / read (0)
//   cmd_addr         burst start address (any alignment)
//   wdata_valid/ready, wdata      write word stream
//   rdata_valid/ready, rdata, rdata_last   read word stream
//   mem_en, mem_we, mem_addr, mem_wdata    RAM access (all 0 when idle)
//   mem_rdata        RAM read data, valid one cycle after a read strobe
//   busy             registered, high whenever the state is not IDLE
//   fsm_state        current controller state, for observation

module ram_burst_ctrl
  import ram_burst_ctrl_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output state_t            fsm_state
);

  localparam int             CNT_W = cnt_width(BURST_LEN);
  localparam logic [CNT_W-1:0] LEN  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  cnt;       // write words accepted
  logic [CNT_W-1:0]  icnt;      // read words issued to the RAM
  logic [CNT_W-1:0]  ocnt;      // read words handed to the host
  logic              inflight;  // a read was issued last cycle

  logic              wr_fire;
  logic              rd_issue;
  logic              pop;
  logic [2:0]        occ;

  logic [1:0]        fcount;
  logic [DATA_W-1:0] fhead;
  logic              fempty;

  assign fsm_state = state;

  assign wr_fire = wdata_ready && wdata_valid;

  // Read credit: words already in the FIFO plus the one returning from the
  // RAM must leave room for the word issued now. A pop in this cycle frees a
  // slot in time, which is what lets a read stream one word per cycle.
  assign occ      = {1'b0, fcount} + {2'b00, inflight};
  assign rd_issue = (state == ST_READ) && (icnt < LEN) &&
                    ((occ - {2'b00, pop}) < 3'd2);

  assign rdata_valid = !fempty;
  assign pop         = rdata_valid && rdata_ready;
  assign rdata       = rdata_valid ? fhead : '0;
  assign rdata_last  = rdata_valid && (ocnt == LAST);

  // RAM strobes: write data is a same-cycle pass-through of the accepted
  // word; all address/data lines are forced to 0 when no access is issued.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (wr_fire) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = base + ADDR_W'(cnt);
      mem_wdata = wdata;
    end else if (rd_issue) begin
      mem_en   = 1'b1;
      mem_addr = base + ADDR_W'(icnt);
    end
  end

  // Returning read data is pushed only when a read was issued under the
  // current burst; after a reset inflight is 0, so stale data is dropped.
  ram_burst_rfifo #(
    .W (DATA_W)
  ) u_rfifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (inflight),
    .push_data (mem_rdata),
    .pop       (pop),
    .count     (fcount),
    .head      (fhead),
    .empty     (fempty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      busy        <= 1'b0;
      base        <= '0;
      cnt         <= '0;
      icnt        <= '0;
      ocnt        <= '0;
      inflight    <= 1'b0;
    end else begin
      inflight <= rd_issue;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            base      <= cmd_addr;
            cnt       <= '0;
            icnt      <= '0;
            ocnt      <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_wr) begin
              state       <= ST_WRITE;
              wdata_ready <= 1'b1;
            end else begin
              state <= ST_READ;
            end
          end
        end

        ST_WRITE: begin
          if (wr_fire) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state       <= ST_IDLE;
              wdata_ready <= 1'b0;
              cmd_ready   <= 1'b1;
              busy        <= 1'b0;
            end
          end
        end

        ST_READ: begin
          if (rd_issue) begin
            icnt <= icnt + 1'b1;
          end
          if (pop) begin
            ocnt <= ocnt + 1'b1;
            if (ocnt == LAST) begin
              state     <= ST_IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end

        default: begin
          state       <= ST_IDLE;
          cmd_ready   <= 1'b1;
          wdata_ready <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl
// Self-checking bench for ram_burst_ctrl. A main instance (ADDR_W=8) talks
// to a behavioural RAM; a second instance (ADDR_W=4) sees the same host
// stimulus and has its write addresses checked for 4-bit wrap-around.

module tb_ram_burst_ctrl;
  import ram_burst_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int BL = 8;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          cmd_valid, cmd_wr, wdata_valid, rdata_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] wdata;
  logic          cmd_ready, wdata_ready, rdata_valid, rdata_last;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  state_t        fsm_state;

  logic          cmd_ready_s, wdata_ready_s, rdata_valid_s, rdata_last_s;
  logic [DW-1:0] rdata_s, mem_wdata_s;
  logic [DW-1:0] mem_rdata_s;
  logic          mem_en_s, mem_we_s, busy_s;
  logic [3:0]    mem_addr_s;
  state_t        fsm_state_s;

  assign mem_rdata_s = '0;

  ram_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL)) u_dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .rdata_last(rdata_last),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .fsm_state(fsm_state)
  );

  ram_burst_ctrl #(.DATA_W(DW), .ADDR_W(4), .BURST_LEN(BL)) u_dut4 (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_s), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr[3:0]),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready_s), .wdata(wdata),
    .rdata_valid(rdata_valid_s), .rdata_ready(rdata_ready), .rdata(rdata_s), .rdata_last(rdata_last_s),
    .mem_en(mem_en_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
    .mem_rdata(mem_rdata_s), .busy(busy_s), .fsm_state(fsm_state_s)
  );

  // ---------------- behavioural RAM ----------------
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata     <= ram[mem_addr];
  end

  // Reference contents, maintained by the drivers only.
  logic [DW-1:0] ref_mem [256];

  // ---------------- scoreboard ----------------
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [3:0]       exp_a4_q[$];
  logic [DW:0]      exp_rd_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  logic [AW+DW-1:0] mon_w;
  logic [DW:0]      mon_r;

  always @(negedge clk) begin
    if (rstn) begin
      if (mem_en && mem_we) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          mon_w = exp_wr_q.pop_front();
          check("wr_addr", mem_addr, mon_w[AW+DW-1:DW]);
          check("wr_data", mem_wdata, mon_w[DW-1:0]);
        end
      end
      if (!mem_en) check("mem_idle_zero", {mem_we, mem_addr, mem_wdata}, 0);
      if (mem_en_s && mem_we_s) begin
        if (exp_a4_q.size() == 0) check("wr4_unexpected", 1, 0);
        else check("wr4_addr", mem_addr_s, exp_a4_q.pop_front());
      end
      if (rdata_valid && rdata_ready) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          mon_r = exp_rd_q.pop_front();
          check("rd_data", rdata, mon_r[DW-1:0]);
          check("rd_last", rdata_last, mon_r[DW]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr);
    int t;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!cmd_ready) check("cmd_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // stall_at: word index before which wdata_valid drops for 3 cycles
  // (any value outside 0..BL-1 means no stall).
  task automatic write_burst(input logic [AW-1:0] addr, input logic [DW-1:0] d0, input int stall_at);
    send_cmd(1'b1, addr);
    for (int i = 0; i < BL; i++) begin
      if (i == stall_at) begin
        wdata_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_mem_en", mem_en, 0);
          check("stall_wready", wdata_ready, 1);
          @(posedge clk); #1;
        end
      end
      wdata_valid = 1'b1;
      wdata       = d0 + DW'(i);
      exp_wr_q.push_back({addr + AW'(i), d0 + DW'(i)});
      exp_a4_q.push_back(addr[3:0] + 4'(i));
      ref_mem[addr + AW'(i)] = d0 + DW'(i);
      @(negedge clk);
      check("wready_in_burst", wdata_ready, 1);
      if (i == BL - 1) check("cmd_ready_last_word", cmd_ready, 0);
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_wr", cmd_ready, 1);
    check("busy_after_wr", busy, 0);
  endtask

  // toggle: flip rdata_ready every cycle; rst_after > 0: reset once that
  // many words have been popped.
  task automatic read_burst(input logic [AW-1:0] addr, input bit toggle, input int rst_after);
    int  n;
    int  np;
    bit  done;
    for (int i = 0; i < BL; i++)
      exp_rd_q.push_back({(i == BL - 1), ref_mem[addr + AW'(i)]});
    rdata_ready = 1'b1;
    send_cmd(1'b0, addr);
    n = 0; np = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (rdata_valid && rdata_ready) begin
        np++;
        if (rdata_last) done = 1'b1;
      end
      if (done || (rst_after > 0 && np == rst_after)) break;
      @(posedge clk); #1;
      if (toggle) rdata_ready = ~rdata_ready;
    end
    if (rst_after > 0) begin
      @(posedge clk); #1;
      rstn = 1'b0;
      rdata_ready = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      exp_rd_q.delete();
      @(negedge clk);
      check("midrst_cmd_ready", cmd_ready, 1);
      check("midrst_outs", {busy, wdata_ready, rdata_valid, rdata_last, rdata, mem_en}, 0);
      check("midrst_state", fsm_state, ST_IDLE);
      return;
    end
    if (!done) check("rd_timeout", 0, 1);
    if (!toggle) check("rd_latency", n, BL + 2);
    @(posedge clk); #1;
    rdata_ready = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rd", cmd_ready, 1);
    check("busy_after_rd", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_outs", {busy, wdata_ready, rdata_valid, rdata_last, rdata, mem_en, mem_we, mem_addr, mem_wdata}, 0);
    check("rst_state", fsm_state, ST_IDLE);
    @(posedge clk); #1;
    rstn = 1'b1;

    write_burst(8'h10, 16'h00A0, -1);   // basic write
    read_burst(8'h10, 1'b0, 0);         // read-back, latency
    write_burst(8'hFC, 16'h00B0, -1);   // wraps FF->00 (and C..3 on 4-bit)
    read_burst(8'hFC, 1'b0, 0);
    write_burst(8'h40, 16'h00C0, 4);    // write stall mid-burst
    read_burst(8'h40, 1'b1, 0);         // back-pressure
    read_burst(8'h10, 1'b0, 3);         // reset mid-read
    read_burst(8'h10, 1'b0, 0);         // restarts from word 0

    for (int k = 0; k < 4; k++) begin
      ra = AW'($urandom_range(0, 255));
      rd = DW'($urandom_range(0, 16'hFFFF));
      write_burst(ra, rd, int'($urandom_range(0, BL)));
      read_burst(ra, bit'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(posedge clk);
    check("wr_q_left", exp_wr_q.size(), 0);
    check("wr4_q_left", exp_a4_q.size(), 0);
    check("rd_q_left", exp_rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
